// File: rtl/data_mem_pkg.sv
// Shared state codes, error-cause codes and byte-lane helpers for data_mem_ctrl.
// Helpers work on a MAX_W-wide word so that any DATA_W up to MAX_W can use them.
package data_mem_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RD_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP    = 2'd2;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_RW_BOTH = 3'd1;
   localparam logic [2:0] ERR_NO_OP   = 3'd2;
   localparam logic [2:0] ERR_RANGE   = 3'd3;
   localparam logic [2:0] ERR_ALIGN   = 3'd4;

   localparam int MAX_W = 256;

   function automatic logic [7:0] lane_extract(input logic [MAX_W-1:0] word,
                                               input logic [4:0]       lane);
      lane_extract = word[lane*8 +: 8];
   endfunction

   function automatic logic [MAX_W-1:0] byte_extend(input logic [7:0] b,
                                                    input logic       sgn);
      byte_extend = {{(MAX_W-8){sgn & b[7]}}, b};
   endfunction

endpackage

// File: rtl/mem_bank.sv
// DEPTH x DATA_W storage with per-lane write enables and asynchronous read.
// The whole array clears synchronously while rst is low.
module mem_bank #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [DATA_W/8-1:0]        byte_we,
   input  logic [$clog2(DEPTH)-1:0]   index,
   input  logic [DATA_W-1:0]          wdata,
   output logic [DATA_W-1:0]          rdata
);

   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] wr_word_d;

   // Merge the enabled lanes into the current word so a byte store keeps the other lanes.
   always_comb begin
      wr_word_d = mem_q[index];
      for (int i = 0; i < NB; i++) begin
         if (byte_we[i]) begin
            wr_word_d[i*8 +: 8] = wdata[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[index] <= wr_word_d;
      end
   end

   assign rdata = mem_q[index];

endmodule

// File: rtl/data_mem_ctrl.sv
// Parametrised data memory for the MEM stage: one request at a time over a
// valid/ready handshake, registered one-cycle response with error reporting.
module data_mem_ctrl
   import data_mem_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              str_byte,
   input  logic              ld_signed,
   input  logic [ADDR_W-1:0] Address,
   input  logic [DATA_W-1:0] WriteData,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] d_out,
   output logic              err,
   output logic [1:0]        dbg_state
);

   localparam int NB    = DATA_W / 8;
   localparam int LB    = $clog2(NB);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   // Handshake: a request transfers on a rising edge where req_valid && req_ready;
   // req_ready is high only in IDLE with rst released. The response has no
   // back-pressure: rsp_valid is a single-cycle strobe the consumer must take.

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rd_word_q, rd_word_d;
   logic              byte_q, byte_d;
   logic              sgn_q, sgn_d;
   logic [LB-1:0]     lane_q, lane_d;
   logic              pend_err_q, pend_err_d;
   logic              pend_rd_q, pend_rd_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] d_out_q, d_out_d;
   logic              err_q, err_d;

   logic              accept;
   logic [ADDR_W-1:0] word_idx;
   logic [LB-1:0]     lane;
   logic [2:0]        cause;
   logic              bank_we;
   logic [NB-1:0]     bank_byte_we;
   logic [DATA_W-1:0] bank_wdata;
   logic [DATA_W-1:0] bank_rdata;
   logic [7:0]        lane_byte;
   logic [DATA_W-1:0] load_byte;

   assign req_ready = rst && (state_q == ST_IDLE);
   assign accept    = req_valid && req_ready;
   assign word_idx  = Address >> LB;
   assign lane      = Address[LB-1:0];

   always_comb begin
      if (MemRead && MemWrite) begin
         cause = ERR_RW_BOTH;
      end else if (!MemRead && !MemWrite) begin
         cause = ERR_NO_OP;
      end else if ((word_idx >> IDX_W) != '0) begin
         cause = ERR_RANGE;
      end else if (!str_byte && (lane != '0)) begin
         cause = ERR_ALIGN;
      end else begin
         cause = ERR_NONE;
      end
   end

   // Stores commit on the accept edge itself; byte stores replicate the byte to every lane.
   assign bank_we      = accept && (cause == ERR_NONE) && MemWrite;
   assign bank_byte_we = str_byte ? (NB'(1) << lane) : '1;
   assign bank_wdata   = str_byte ? {NB{WriteData[7:0]}} : WriteData;

   mem_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      (bank_we),
      .byte_we (bank_byte_we),
      .index   (word_idx[IDX_W-1:0]),
      .wdata   (bank_wdata),
      .rdata   (bank_rdata)
   );

   assign lane_byte = lane_extract(MAX_W'(rd_word_q), 5'(lane_q));
   assign load_byte = DATA_W'(byte_extend(lane_byte, sgn_q));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rd_word_d   = rd_word_q;
      byte_d      = byte_q;
      sgn_d       = sgn_q;
      lane_d      = lane_q;
      pend_err_d  = pend_err_q;
      pend_rd_d   = pend_rd_q;
      rsp_valid_d = 1'b0;
      d_out_d     = d_out_q;
      err_d       = err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               rd_word_d  = bank_rdata;
               byte_d     = str_byte;
               sgn_d      = ld_signed;
               lane_d     = lane;
               pend_err_d = (cause != ERR_NONE);
               pend_rd_d  = MemRead && (cause == ERR_NONE);
               if ((cause == ERR_NONE) && MemRead && (LATENCY > 1)) begin
                  state_d = ST_RD_WAIT;
                  cnt_d   = CNT_W'(LATENCY - 1);
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_RD_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_d == '0) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            // The response registers load here, so rsp_valid shows in the cycle after RESP.
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
            err_d       = pend_err_q;
            if (pend_err_q || !pend_rd_q) begin
               d_out_d = '0;
            end else if (byte_q) begin
               d_out_d = load_byte;
            end else begin
               d_out_d = rd_word_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rd_word_q   <= '0;
         byte_q      <= 1'b0;
         sgn_q       <= 1'b0;
         lane_q      <= '0;
         pend_err_q  <= 1'b0;
         pend_rd_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         d_out_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rd_word_q   <= rd_word_d;
         byte_q      <= byte_d;
         sgn_q       <= sgn_d;
         lane_q      <= lane_d;
         pend_err_q  <= pend_err_d;
         pend_rd_q   <= pend_rd_d;
         rsp_valid_q <= rsp_valid_d;
         d_out_q     <= d_out_d;
         err_q       <= err_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign d_out     = d_out_q;
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a vector table of single requests plus
// hand-written reset-abort and back-to-back read sequences.
module tb_data_mem_ctrl;
   import data_mem_pkg::*;

   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 16;
   localparam int DEPTH   = 256;
   localparam int LATENCY = 2;
   localparam int NVEC    = 24;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              MemRead = 1'b0;
   logic              MemWrite = 1'b0;
   logic              str_byte = 1'b0;
   logic              ld_signed = 1'b0;
   logic [ADDR_W-1:0] Address = '0;
   logic [DATA_W-1:0] WriteData = '0;
   logic              rsp_valid;
   logic [DATA_W-1:0] d_out;
   logic              err;
   logic [1:0]        dbg_state;

   int total = 0;
   int bad   = 0;
   logic [DATA_W-1:0] exp_q[$];

   typedef struct {
      logic        rd;
      logic        wr;
      logic        bm;
      logic        sg;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_d;
      logic        exp_e;
      int          exp_lat;
   } vec_t;

   vec_t vecs[NVEC];

   always #5 clk = ~clk;

   data_mem_ctrl #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .DEPTH   (DEPTH),
      .LATENCY (LATENCY)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .str_byte  (str_byte),
      .ld_signed (ld_signed),
      .Address   (Address),
      .WriteData (WriteData),
      .rsp_valid (rsp_valid),
      .d_out     (d_out),
      .err       (err),
      .dbg_state (dbg_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic scramble_inputs();
      MemRead   = 1'($urandom_range(0, 1));
      MemWrite  = 1'($urandom_range(0, 1));
      str_byte  = 1'($urandom_range(0, 1));
      ld_signed = 1'($urandom_range(0, 1));
      Address   = 16'($urandom_range(0, 65535));
      WriteData = 16'($urandom_range(0, 65535));
   endtask

   // Issue one request, wait for its response, check latency/data/err and the hold cycle.
   task automatic run_req(input vec_t v, input string tag);
      int wait_n;
      int lat;
      bit seen;
      @(negedge clk);
      req_valid = 1'b1;
      MemRead   = v.rd;
      MemWrite  = v.wr;
      str_byte  = v.bm;
      ld_signed = v.sg;
      Address   = v.addr;
      WriteData = v.wdata;
      wait_n = 0;
      while (!req_ready && wait_n < 20) begin
         @(negedge clk);
         wait_n++;
      end
      if (!req_ready) begin
         check({tag, "_ready"}, 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      scramble_inputs();
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 8) begin
         @(posedge clk);
         #1;
         lat++;
         if (rsp_valid) seen = 1'b1;
      end
      check({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
      check({tag, "_dout"}, 32'(d_out), 32'(v.exp_d));
      check({tag, "_err"}, 32'(err), 32'(v.exp_e));
      @(posedge clk);
      #1;
      check({tag, "_strobe_end"}, 32'(rsp_valid), 32'd0);
      check({tag, "_hold"}, 32'(d_out), 32'(v.exp_d));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] b2b_data[4];
      int acc_cyc[4];
      int acc_n;
      int rsp_n;
      int cyc;
      bit rdy;
      bit seen;
      vec_t v;

      //           rd wr bm sg  addr      wdata     exp_d     e  lat
      vecs[0]  = '{1, 0, 0, 0, 16'h0004, 16'h0000, 16'h0000, 0, 2};
      vecs[1]  = '{0, 1, 0, 0, 16'h0004, 16'hABCD, 16'h0000, 0, 1};
      vecs[2]  = '{1, 0, 0, 0, 16'h0004, 16'h0000, 16'hABCD, 0, 2};
      vecs[3]  = '{0, 1, 1, 0, 16'h0005, 16'h0012, 16'h0000, 0, 1};
      vecs[4]  = '{1, 0, 0, 0, 16'h0004, 16'h0000, 16'h12CD, 0, 2};
      vecs[5]  = '{1, 0, 1, 1, 16'h0004, 16'h0000, 16'hFFCD, 0, 2};
      vecs[6]  = '{1, 0, 1, 0, 16'h0004, 16'h0000, 16'h00CD, 0, 2};
      vecs[7]  = '{1, 0, 1, 1, 16'h0005, 16'h0000, 16'h0012, 0, 2};
      vecs[8]  = '{1, 1, 0, 0, 16'h0004, 16'h5555, 16'h0000, 1, 1};
      vecs[9]  = '{1, 0, 0, 0, 16'h0005, 16'h0000, 16'h0000, 1, 1};
      vecs[10] = '{0, 1, 0, 0, 16'h0200, 16'h7777, 16'h0000, 1, 1};
      vecs[11] = '{0, 0, 0, 0, 16'h0004, 16'h6666, 16'h0000, 1, 1};
      vecs[12] = '{1, 0, 0, 0, 16'h0004, 16'h0000, 16'h12CD, 0, 2};
      vecs[13] = '{1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 2};
      vecs[14] = '{0, 1, 1, 0, 16'h01FF, 16'h0080, 16'h0000, 0, 1};
      vecs[15] = '{1, 0, 1, 1, 16'h01FF, 16'h0000, 16'hFF80, 0, 2};
      vecs[16] = '{1, 0, 0, 0, 16'h01FE, 16'h0000, 16'h8000, 0, 2};
      vecs[17] = '{0, 1, 1, 0, 16'h01FE, 16'hFF34, 16'h0000, 0, 1};
      vecs[18] = '{1, 0, 0, 0, 16'h01FE, 16'h0000, 16'h8034, 0, 2};
      vecs[19] = '{1, 0, 1, 0, 16'h01FF, 16'h0000, 16'h0080, 0, 2};
      vecs[20] = '{1, 0, 1, 0, 16'h0200, 16'h0000, 16'h0000, 1, 1};
      vecs[21] = '{0, 1, 0, 0, 16'h0103, 16'h1234, 16'h0000, 1, 1};
      vecs[22] = '{1, 0, 1, 1, 16'hFFFF, 16'h0000, 16'h0000, 1, 1};
      vecs[23] = '{1, 0, 0, 0, 16'h0102, 16'h0000, 16'h0000, 0, 2};

      b2b_data[0] = 16'h1111;
      b2b_data[1] = 16'h2222;
      b2b_data[2] = 16'h3333;
      b2b_data[3] = 16'h4444;

      // Reset state.
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_dout", 32'(d_out), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_release_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < NVEC; i++) begin
         run_req(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset one cycle after a read is accepted: no response, array cleared.
      v = '{0, 1, 0, 0, 16'h0004, 16'hABCD, 16'h0000, 0, 1};
      run_req(v, "pre_abort_wr");
      @(negedge clk);
      req_valid = 1'b1;
      MemRead   = 1'b1;
      MemWrite  = 1'b0;
      str_byte  = 1'b0;
      Address   = 16'h0004;
      check("abort_ready_before", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      scramble_inputs();
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) seen = 1'b1;
         check($sformatf("abort_ready_low%0d", c), 32'(req_ready), 32'd0);
      end
      check("abort_no_rsp", 32'(seen), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      v = '{1, 0, 0, 0, 16'h0004, 16'h0000, 16'h0000, 0, 2};
      run_req(v, "post_abort_rd4");
      v = '{1, 0, 0, 0, 16'h01FE, 16'h0000, 16'h0000, 0, 2};
      run_req(v, "post_abort_rd1fe");

      // Back-to-back reads with req_valid held high.
      for (int i = 0; i < 4; i++) begin
         v = '{0, 1, 0, 0, 16'(16'h0010 + 2 * i), b2b_data[i], 16'h0000, 0, 1};
         run_req(v, $sformatf("b2b_fill%0d", i));
      end
      acc_n = 0;
      rsp_n = 0;
      cyc   = 0;
      @(negedge clk);
      req_valid = 1'b1;
      MemRead   = 1'b1;
      MemWrite  = 1'b0;
      str_byte  = 1'b0;
      ld_signed = 1'b0;
      while (rsp_n < 4 && cyc < 40) begin
         Address = 16'(16'h0010 + 2 * acc_n);
         if (dbg_state != ST_IDLE) begin
            check($sformatf("b2b_busy_ready_c%0d", cyc), 32'(req_ready), 32'd0);
         end
         rdy = req_ready;
         @(posedge clk);
         cyc++;
         if (rdy && req_valid) begin
            if (acc_n < 4) acc_cyc[acc_n] = cyc;
            exp_q.push_back(b2b_data[acc_n % 4]);
            acc_n++;
         end
         #1;
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               check($sformatf("b2b_extra_rsp%0d", rsp_n), 32'd1, 32'd0);
            end else begin
               check($sformatf("b2b_rsp%0d_dout", rsp_n), 32'(d_out), 32'(exp_q.pop_front()));
               check($sformatf("b2b_rsp%0d_err", rsp_n), 32'(err), 32'd0);
            end
            rsp_n++;
         end
         @(negedge clk);
         if (acc_n >= 4) req_valid = 1'b0;
      end
      check("b2b_rsp_count", 32'(rsp_n), 32'd4);
      check("b2b_acc_count", 32'(acc_n), 32'd4);
      if (acc_n >= 4) begin
         for (int i = 1; i < 4; i++) begin
            check($sformatf("b2b_spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
